pipe_stage_reg: RTL

Parametrised, handshaked pipeline stage register for the MIPS pipeline, replacing the fixed-field ID/EX-style register with a generic payload of control and data bits. Sits between any two pipeline stages, such as ID→EXE or EXE→MEM. It carries a valid/ready handshake with backpressure, a synchronous flush, and bubble semantics: control bits read as zero whenever the stage is empty. A compile-time option adds a two-entry skid buffer so that `in_ready` has no combinational path from `out_ready`.

---
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register with bubble-zeroed control field
// Define PIPE_REG_SKID_EN for the two-entry skid build, where in_ready depends only on registered state and flush.
`timescale 1ns/1ps
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 143,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bp_cycles
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_state_t;

  occ_state_t        state, state_nxt;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic              in_fire, out_fire, load_head_in;
`ifdef PIPE_REG_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              load_skid, load_head_skid;
`endif

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = head_ctrl & {CTRL_W{out_valid}};
  assign out_data  = head_data;
  assign occ       = state;

  // Gating with rst keeps the stage closed for the whole reset window.
`ifdef PIPE_REG_SKID_EN
  assign in_ready = rst & (state != TWO) & ~flush;
`else
  assign in_ready = rst & (~out_valid | out_ready) & ~flush;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    load_head_in = 1'b0;
`ifdef PIPE_REG_SKID_EN
    load_skid      = 1'b0;
    load_head_skid = 1'b0;
`endif
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt    = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_head_in = 1'b1;
`ifdef PIPE_REG_SKID_EN
          end else if (in_fire) begin
            state_nxt = TWO;
            load_skid = 1'b1;
`endif
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
`ifdef PIPE_REG_SKID_EN
        TWO: begin
          if (out_fire) begin
            state_nxt      = ONE;
            load_head_skid = 1'b1;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  // Data is deliberately not cleared on flush or drain; only out_ctrl is masked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ctrl <= '0;
      head_data <= '0;
    end else if (load_head_in) begin
      head_ctrl <= in_ctrl;
      head_data <= in_data;
`ifdef PIPE_REG_SKID_EN
    end else if (load_head_skid) begin
      head_ctrl <= skid_ctrl;
      head_data <= skid_data;
`endif
    end
  end

`ifdef PIPE_REG_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_cycles <= '0;
    end else if (out_valid && !out_ready && (bp_cycles != '1)) begin
      bp_cycles <= bp_cycles + CNT_W'(1);
    end
  end

endmodule
